subbytes_seq: RTL

Iterative AES-128 SubBytes stage that sits directly upstream of the ShiftRows stage. It accepts a 128-bit state from the AddRoundKey/round-input path over a valid/ready handshake and substitutes every byte through the FIPS-197 forward S-box, LANES bytes per clock. It then presents the 128-bit substituted state on `sb` for ShiftRows. Sharing a small number of S-box instances across cycles trades latency for area in the custom core.

---
 rtl/aes_pkg.sv | 40 ++++
 rtl/subbytes_seq_if.sv | 27 ++
 rtl/aes_sbox.sv | 17 +
 rtl/subbytes_seq.sv | 87 ++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// =============================================================================
// Package : aes_pkg
// Brief   : Shared AES constants: forward S-box, SubBytes FSM encoding, byte map
// Rev     : 1.0
// =============================================================================
`default_nettype none

package aes_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [7:0] AES_SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Byte 0 of the 128-bit state lives in the MSB; returns that byte's top bit.
   function automatic int byte_msb(input int idx);
      return 127 - 8 * idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/subbytes_seq_if.sv
// =============================================================================
// Interface : subbytes_seq_if
// Brief     : Input/output valid-ready handshakes of the SubBytes stage
// Rev       : 1.0
// =============================================================================
`default_nettype none

interface subbytes_seq_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] sa;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] sb;

   modport master (
      output in_valid, sa, out_ready,
      input  in_ready, out_valid, sb
   );

   modport slave (
      input  in_valid, sa, out_ready,
      output in_ready, out_valid, sb
   );
endinterface

`default_nettype wire

// File: rtl/aes_sbox.sv
// =============================================================================
// Module : aes_sbox
// Brief  : Combinational FIPS-197 forward S-box, shared with key expansion
// Rev    : 1.0
// =============================================================================
`default_nettype none

module aes_sbox
   import aes_pkg::*;
(
   input  wire logic [7:0] i_din,
   output logic      [7:0] o_dout
);
   assign o_dout = AES_SBOX[i_din];
endmodule

`default_nettype wire

// File: rtl/subbytes_seq.sv
// =============================================================================
// Module : subbytes_seq
// Brief  : Iterative AES SubBytes, LANES bytes per clock, valid/ready in and out
// Rev    : 1.0
// =============================================================================
`default_nettype none

module subbytes_seq
   import aes_pkg::*;
#(
   parameter int LANES = 4
)(
   input  wire logic     clk,
   input  wire logic     rst,
   subbytes_seq_if.slave bus
);
   localparam int c_ncyc    = 16 / LANES;
   localparam int c_cnt_w   = (c_ncyc > 1) ? $clog2(c_ncyc) : 1;
   localparam int c_chunk_w = 8 * LANES;

   logic [1:0]           r_state;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [127:0]         r_work;
   logic                 r_in_ready;
   logic                 r_out_valid;

   logic [c_chunk_w-1:0] w_chunk;
   logic [c_chunk_w-1:0] w_chunk_sub;

   assign w_chunk = r_work[byte_msb(int'(r_cnt) * LANES) -: c_chunk_w];

   generate
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         aes_sbox u_sbox (
            .i_din  (w_chunk[c_chunk_w-1-8*l -: 8]),
            .o_dout (w_chunk_sub[c_chunk_w-1-8*l -: 8])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_work      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_work     <= bus.sa;
                  r_cnt      <= '0;
                  r_state    <= BUSY;
                  r_in_ready <= 1'b0;
               end
            end
            BUSY: begin
               r_work[byte_msb(int'(r_cnt) * LANES) -: c_chunk_w] <= w_chunk_sub;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_cnt_w'(c_ncyc - 1)) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.sb        = r_work;
endmodule

`default_nettype wire
